intc_sched: RTL and testbench
=============================

Name: intc_sched

Overview:
- Interrupt controller and scheduler that sits in front of the decode stage.
- Captures edges on the 16 external interrupt lines, applies a software-written mask and a global enable, and selects the highest-priority pending source.
- Presents that source to decode as a one-hot interrupt_state word plus a vector in the range 8'hF0..8'hFF.
- Sequences the request / take / return-from-interrupt handshake with the writeback stage; only one interrupt is in service at a time (no nesting).

Parameters:
- NUM_IRQ, 16: number of interrupt lines. Fixed at 16; the vector math relies on it.
- VEC_BASE, 8'hF0: vector for line 0. Line n uses VEC_BASE+n, so line 15 maps to 8'hFF.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  global clock enable; all state holds when low
- irq_in  in  16  raw interrupt lines, active-high, edge-triggered
- gie  in  1  global interrupt enable from the control regfile
- imr_we  in  1  mask register write strobe
- imr_wdata  in  16  new mask value; 1 = line enabled
- clr_we  in  1  software pending-clear strobe
- clr_wdata  in  16  write-1-to-clear pattern for pending bits
- take  in  1  interrupt reached writeback (interrupt_in_wb)
- rfi  in  1  return-from-interrupt reached writeback (rfi_in_wb)
- interrupt_state  out  16  one-hot of the requested line while in REQ, else 0
- irq_req  out  1  request active
- irq_vec  out  8  VEC_BASE + selected id while in REQ, else 0
- imr  out  16  current mask
- pending  out  16  pending bits (before masking)
- in_service  out  1  high while in SERVICE
- spurious  out  1  sticky error flag: take seen outside REQ, or rfi seen outside SERVICE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Registers: pending=0, imr=0, irq_prev=0, state=IDLE, id=0, spurious=0.
  - Outputs: interrupt_state=0, irq_req=0, irq_vec=0, in_service=0.
  - Reset asserted mid-REQ or mid-SERVICE aborts immediately to IDLE; no state survives.
- Clock enable: every register updates only on posedge clk with clk_en=1.
- Edge capture:
  - irq_prev <= irq_in each enabled cycle.
  - rise = irq_in & ~irq_prev; pending |= rise.
  - A level held high sets pending once only.
- Pending clear sources:
  - clr_we clears the bits set in clr_wdata.
  - take while in REQ clears pending[id].
  - If a rise and a clear hit the same bit in the same cycle, set wins.
- Mask update: imr <= imr_wdata on imr_we, effective the next cycle.
- eligible = pending & imr, gated by gie. sel = index of the highest set bit of eligible (bit 15 is highest priority).
- FSM:
  - IDLE: if eligible != 0, latch id <= sel and go to REQ; else stay.
  - REQ: irq_req=1, interrupt_state = 1<<id, irq_vec = VEC_BASE+id. The id stays latched; a higher-priority arrival does not preempt it.
    - take=1: go to SERVICE and clear pending[id].
    - Else, if gie=0, imr[id]=0, or pending[id] was cleared by software: withdraw to IDLE with no take.
    - take has priority over withdraw in the same cycle.
  - SERVICE: outputs quiet except in_service=1; pending may still accumulate.
    - rfi=1: go to IDLE.
    - A new request may issue in the cycle after return to IDLE.
- Outputs are registered; there is no combinational path from any input to any output.
- Latency, with irq_in rising before edge E0 and gie=1, imr bit set:
  - pending set at E0.
  - REQ entered at E1; irq_req is high after E1.
  - take sampled at Ek gives irq_req=0 and in_service=1 after Ek.
- spurious is set by take in IDLE or SERVICE, or by rfi in IDLE or REQ. Such events are otherwise ignored; only reset clears the flag.

Optional Feature:
- INTC_SYNC_EN defined: irq_in passes through a two-flop synchronizer (reset to 0) before edge detection. Capture latency grows by 2 cycles (pending set at E2, REQ at E3).
- Undefined: irq_in is treated as already synchronous; latency is as above.

Test Plan:
- Reset, then imr=16'hFFFF, gie=1, pulse irq_in[3] -> pending=16'h0008 after E0; irq_req=1, irq_vec=8'hF3, interrupt_state=16'h0008 after E1.
- irq_in[2] and irq_in[14] rise together -> id=14, irq_vec=8'hFE; take -> pending=16'h0004, in_service=1; rfi -> IDLE, then REQ with irq_vec=8'hF2.
- In REQ for line 5, write imr=16'hFFDF -> withdraw to IDLE, irq_req=0, pending[5] still 1; restore imr -> REQ with irq_vec=8'hF5 again.
- take pulsed while IDLE -> spurious=1, state unchanged; rst_n low mid-SERVICE -> all outputs 0 immediately.
- irq_in[0] held high for 10 cycles -> a single pending set; after take and rfi, no second request.
- clk_en=0 during an irq_in rise and fall -> no capture and no state change; with INTC_SYNC_EN, check the REQ latency of 3 cycles.

Source files
------------

// File: rtl/intc_sched.sv
`default_nettype none
// ============================================================================
// Module      : intc_sched
// Description : Interrupt controller / scheduler in front of decode. Captures
//               rising edges on 16 interrupt lines, masks them, picks the
//               highest-priority pending line and runs the request / take /
//               return-from-interrupt handshake with writeback (no nesting).
// Options     : INTC_SYNC_EN - adds a two-flop synchronizer on irq_in
//               (capture latency grows by two cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module intc_sched #(
  parameter int         NUM_IRQ  = 16,
  parameter logic [7:0] VEC_BASE = 8'hF0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               gie,
  input  logic               imr_we,
  input  logic [NUM_IRQ-1:0] imr_wdata,
  input  logic               clr_we,
  input  logic [NUM_IRQ-1:0] clr_wdata,
  input  logic               take,
  input  logic               rfi,
  output logic [NUM_IRQ-1:0] interrupt_state,
  output logic               irq_req,
  output logic [7:0]         irq_vec,
  output logic [NUM_IRQ-1:0] imr,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic               spurious
);

  localparam int ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    id;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [ID_W-1:0]    sel;
  logic               sel_valid;
  logic               take_hit;
  logic               spurious_evt;

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] sync_ff1;
  logic [NUM_IRQ-1:0] sync_ff2;

  // Two-flop synchronizer for asynchronous interrupt sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else if (clk_en) begin
      sync_ff1 <= irq_in;
      sync_ff2 <= sync_ff1;
    end
  end

  assign irq_s = sync_ff2;
`else
  assign irq_s = irq_in;
`endif

  assign rise      = irq_s & ~irq_prev;
  assign eligible  = gie ? (pending & imr) : '0;
  assign id_onehot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << id;
  assign take_hit  = (state == ST_REQ) && take;

  // Software clear plus the implicit clear of the line being taken
  assign clr_mask  = (clr_we ? clr_wdata : '0) | (take_hit ? id_onehot : '0);

  // Handshake events that do not match the current state are flagged
  assign spurious_evt = (take && (state != ST_REQ)) ||
                        (rfi  && (state != ST_SERVICE));

  // Priority encoder: the last hit in ascending order is the highest line
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) begin
        sel       = ID_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  // Edge capture, pending/mask registers and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev <= '0;
      pending  <= '0;
      imr      <= '0;
      spurious <= 1'b0;
    end else if (clk_en) begin
      irq_prev <= irq_s;
      // A rise coinciding with a clear on the same bit keeps the bit set
      pending  <= (pending & ~clr_mask) | rise;
      if (imr_we) begin
        imr <= imr_wdata;
      end
      if (spurious_evt) begin
        spurious <= 1'b1;
      end
    end
  end

  // State register and latched request id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      id    <= '0;
    end else if (clk_en) begin
      state <= state_next;
      if ((state == ST_IDLE) && sel_valid) begin
        id <= sel;
      end
    end
  end

  // Next-state logic; take wins over a simultaneous withdraw condition
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (take) begin
          state_next = ST_SERVICE;
        end else if (!gie || !imr[id] || !pending[id]) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (rfi) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and id
  always_comb begin
    irq_req         = (state == ST_REQ);
    in_service      = (state == ST_SERVICE);
    interrupt_state = irq_req ? id_onehot : '0;
    irq_vec         = irq_req ? (VEC_BASE + 8'(id)) : 8'h00;
  end

endmodule
`default_nettype wire

// File: tb/tb_intc_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_intc_sched
// Description : Directed self-checking bench for intc_sched. Expected values
//               are hand-computed; SYNC_LAT accounts for the optional
//               INTC_SYNC_EN input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intc_sched;

`ifdef INTC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [15:0] irq_in;
  logic        gie;
  logic        imr_we;
  logic [15:0] imr_wdata;
  logic        clr_we;
  logic [15:0] clr_wdata;
  logic        take;
  logic        rfi;
  logic [15:0] interrupt_state;
  logic        irq_req;
  logic [7:0]  irq_vec;
  logic [15:0] imr;
  logic [15:0] pending;
  logic        in_service;
  logic        spurious;

  int n_checks = 0;
  int n_fail   = 0;

  intc_sched #(.NUM_IRQ(16), .VEC_BASE(8'hF0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk_en          (clk_en),
    .irq_in          (irq_in),
    .gie             (gie),
    .imr_we          (imr_we),
    .imr_wdata       (imr_wdata),
    .clr_we          (clr_we),
    .clr_wdata       (clr_wdata),
    .take            (take),
    .rfi             (rfi),
    .interrupt_state (interrupt_state),
    .irq_req         (irq_req),
    .irq_vec         (irq_vec),
    .imr             (imr),
    .pending         (pending),
    .in_service      (in_service),
    .spurious        (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Pulse one cycle of irq_in and wait until the pending bit has been captured
  task automatic pulse_irq(input logic [15:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
    step(SYNC_LAT);
  endtask

  task automatic do_take();
    take = 1'b1;
    tick();
    take = 1'b0;
  endtask

  task automatic do_rfi();
    rfi = 1'b1;
    tick();
    rfi = 1'b0;
  endtask

  task automatic write_imr(input logic [15:0] val);
    imr_we    = 1'b1;
    imr_wdata = val;
    tick();
    imr_we    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; irq_in = '0; gie = 1'b0;
    imr_we = 1'b0; imr_wdata = '0; clr_we = 1'b0; clr_wdata = '0;
    take = 1'b0; rfi = 1'b0;
    step(2);

    // Reset state
    check("rst_irq_req", 32'(irq_req), 32'h0);
    check("rst_irq_vec", 32'(irq_vec), 32'h0);
    check("rst_istate", 32'(interrupt_state), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_imr", 32'(imr), 32'h0);
    check("rst_in_service", 32'(in_service), 32'h0);
    check("rst_spurious", 32'(spurious), 32'h0);

    rst_n = 1'b1;
    tick();
    gie = 1'b1;
    write_imr(16'hFFFF);
    check("imr_write", 32'(imr), 32'hFFFF);

    // Single line 3: capture, then request one cycle later
    pulse_irq(16'h0008);
    check("t1_pending", 32'(pending), 32'h0008);
    check("t1_no_req_yet", 32'(irq_req), 32'h0);
    tick();
    check("t1_irq_req", 32'(irq_req), 32'h1);
    check("t1_irq_vec", 32'(irq_vec), 32'hF3);
    check("t1_istate", 32'(interrupt_state), 32'h0008);
    do_take();
    check("t1_take_req", 32'(irq_req), 32'h0);
    check("t1_in_service", 32'(in_service), 32'h1);
    check("t1_take_pend", 32'(pending), 32'h0);
    check("t1_svc_vec", 32'(irq_vec), 32'h0);
    do_rfi();
    check("t1_rfi_svc", 32'(in_service), 32'h0);
    check("t1_rfi_req", 32'(irq_req), 32'h0);

    // Lines 2 and 14 together: 14 wins, 2 follows after return
    pulse_irq(16'h4004);
    check("t2_pending", 32'(pending), 32'h4004);
    tick();
    check("t2_vec14", 32'(irq_vec), 32'hFE);
    check("t2_istate14", 32'(interrupt_state), 32'h4000);
    do_take();
    check("t2_pend_after_take", 32'(pending), 32'h0004);
    check("t2_in_service", 32'(in_service), 32'h1);
    do_rfi();
    check("t2_idle_after_rfi", 32'(irq_req), 32'h0);
    tick();
    check("t2_req2", 32'(irq_req), 32'h1);
    check("t2_vec2", 32'(irq_vec), 32'hF2);
    do_take();
    do_rfi();

    // Line 5: mask withdraw, then restore
    pulse_irq(16'h0020);
    tick();
    check("t3_vec5", 32'(irq_vec), 32'hF5);
    write_imr(16'hFFDF);
    check("t3_still_req", 32'(irq_req), 32'h1);
    tick();
    check("t3_withdrawn", 32'(irq_req), 32'h0);
    check("t3_pend_kept", 32'(pending), 32'h0020);
    tick();
    check("t3_stay_idle", 32'(irq_req), 32'h0);
    write_imr(16'hFFFF);
    check("t3_not_yet", 32'(irq_req), 32'h0);
    tick();
    check("t3_rereq", 32'(irq_req), 32'h1);
    check("t3_rereq_vec", 32'(irq_vec), 32'hF5);
    do_take();
    do_rfi();

    // Set beats clear on the same bit; then a software clear withdraws
    irq_in = 16'h0010;
    for (int i = 0; i <= SYNC_LAT; i++) begin
      if (i == SYNC_LAT) begin
        clr_we    = 1'b1;
        clr_wdata = 16'h0010;
      end
      tick();
      if (i == 0) irq_in = '0;
    end
    clr_we = 1'b0;
    check("t4_set_wins", 32'(pending), 32'h0010);
    tick();
    check("t4_req4", 32'(irq_vec), 32'hF4);
    clr_we = 1'b1;
    clr_wdata = 16'h0010;
    tick();
    clr_we = 1'b0;
    check("t4_cleared", 32'(pending), 32'h0);
    tick();
    check("t4_sw_withdraw", 32'(irq_req), 32'h0);

    // Spurious take in IDLE
    do_take();
    check("t5_spurious", 32'(spurious), 32'h1);
    check("t5_idle_req", 32'(irq_req), 32'h0);
    check("t5_idle_svc", 32'(in_service), 32'h0);

    // Asynchronous reset mid-SERVICE
    pulse_irq(16'h0002);
    tick();
    do_take();
    check("t6_in_service", 32'(in_service), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_svc", 32'(in_service), 32'h0);
    check("t6_rst_spur", 32'(spurious), 32'h0);
    check("t6_rst_imr", 32'(imr), 32'h0);
    check("t6_rst_req", 32'(irq_req), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    write_imr(16'hFFFF);

    // Level held high on line 0: one capture only
    irq_in = 16'h0001;
    step(3 + SYNC_LAT);
    check("t7_req0", 32'(irq_vec), 32'hF0);
    check("t7_pend0", 32'(pending), 32'h0001);
    do_take();
    step(5);
    check("t7_no_reset_pend", 32'(pending), 32'h0);
    irq_in = '0;
    do_rfi();
    tick();
    check("t7_no_second_req", 32'(irq_req), 32'h0);

    // clk_en low across an edge: nothing captured
    clk_en = 1'b0;
    irq_in = 16'h0100;
    tick();
    irq_in = '0;
    tick();
    clk_en = 1'b1;
    step(3 + SYNC_LAT);
    check("t8_no_capture", 32'(pending), 32'h0);
    check("t8_no_req", 32'(irq_req), 32'h0);

    // clk_en low in REQ: take ignored, state held
    pulse_irq(16'h0100);
    tick();
    check("t8_req8", 32'(irq_vec), 32'hF8);
    clk_en = 1'b0;
    take   = 1'b1;
    tick();
    check("t8_hold_req", 32'(irq_req), 32'h1);
    check("t8_hold_pend", 32'(pending), 32'h0100);
    take   = 1'b0;
    clk_en = 1'b1;
    do_take();
    check("t8_take_svc", 32'(in_service), 32'h1);
    do_rfi();
    check("t8_done", 32'(in_service), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
